// File: rtl/uart_tx_serializer_if.sv
// Handshake and serial-line bundle between the TX FIFO / holding register and the UART TX serializer.
// The master side drives the FIFO, the holding register, the baud tick and the frame config.
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic              baud_tick_i;
    logic              fifo_empty_i;
    logic [DATA_W-1:0] data_i;
    logic              parity_en_i;
    logic              parity_odd_i;
    logic              stop2_i;
    logic              load_o;
    logic              tx_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  baud_tick_i,
        input  fifo_empty_i,
        input  data_i,
        input  parity_en_i,
        input  parity_odd_i,
        input  stop2_i,
        output load_o,
        output tx_o,
        output busy_o,
        output done_o
    );

    modport master (
        output baud_tick_i,
        output fifo_empty_i,
        output data_i,
        output parity_en_i,
        output parity_odd_i,
        output stop2_i,
        input  load_o,
        input  tx_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops a byte from the TX FIFO via the holding register and shifts out
// start, LSB-first data, optional parity and one or two stop bits, OVERSAMPLE baud ticks per bit.
module uart_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_tx_serializer_if.slave bus
);
    localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_parity_bit;
    logic              r_parity_en;
    logic              r_stop2;
    logic              r_tx;
    logic              r_done;

    logic w_load;
    logic w_bit_end;
    logic w_in_frame;

    // The pop is held off while reset is asserted so an aborted frame never consumes a FIFO entry.
    assign w_load     = (r_state == S_IDLE) && !bus.fifo_empty_i && !rst_i;
    assign w_bit_end  = bus.baud_tick_i && (r_tick_cnt == LAST_TICK);
    assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);

    assign bus.load_o = w_load;
    assign bus.tx_o   = r_tx;
    assign bus.busy_o = (r_state != S_IDLE) || w_load;
    assign bus.done_o = r_done;

    // r_tx is loaded with the level of the state being entered, so the line always matches r_state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity_bit <= 1'b0;
            r_parity_en  <= 1'b0;
            r_stop2      <= 1'b0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_in_frame && bus.baud_tick_i) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_load) begin
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_shift      <= bus.data_i;
                    r_parity_en  <= bus.parity_en_i;
                    r_stop2      <= bus.stop2_i;
                    r_parity_bit <= (^bus.data_i) ^ bus.parity_odd_i;
                    r_tick_cnt   <= '0;
                    r_tx         <= 1'b0;
                    r_state      <= S_START;
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            if (r_parity_en) begin
                                r_tx    <= r_parity_bit;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop2 && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
